tlight_v2: RTL and testbench
============================

TLIGHT_V2 -- requirements
Module: tlight_v2

Interface
REQ-001 Parameter TIMER_W, default 8: timer register width in bits.
REQ-002 Parameter GREEN_DURATION, default 16: cycles spent in each green phase.
REQ-003 Parameter YELLOW_DURATION, default 4: cycles spent in each yellow phase.
REQ-004 Parameter ALL_RED_DURATION, default 2: cycles of all-red clearance between phases.
REQ-005 Parameter WALK_DURATION, default 10: cycles of the pedestrian walk phase.
REQ-006 Parameter FLASH_HALF_PERIOD, default 8: cycles per on/off half of the flashing-yellow blink.
REQ-007 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port ped_req, input, 1 bit: pedestrian request; sampled as a level each cycle.
REQ-010 Port flash, input, 1 bit: night flashing-mode request; functional only when TLIGHT_FLASH_EN is defined.
REQ-011 Port ns, output, 3 bits: north-south lamps, one-hot: RED=100, YELLOW=010, GREEN=001, dark=000.
REQ-012 Port we, output, 3 bits: west-east lamps, same encoding as ns.
REQ-013 Port walk, output, 1 bit: pedestrian walk lamp.
REQ-014 Port ped_pending, output, 1 bit: a pedestrian request is latched and not yet served.

Function
REQ-015 States SHALL be NS_GREEN, NS_YELLOW, CLR_A, WE_GREEN, WE_YELLOW, CLR_B, WALK and FLASH.
REQ-016 Lamp outputs per state SHALL be as follows.
- NS_GREEN: ns=GREEN, we=RED.
- NS_YELLOW: ns=YELLOW, we=RED.
- WE_GREEN: ns=RED, we=GREEN.
- WE_YELLOW: ns=RED, we=YELLOW.
- CLR_A, CLR_B, WALK: ns=we=RED.
- walk=1 only in WALK.
REQ-017 Each timed state with duration D SHALL last exactly D cycles: timer loads D-1 on entry, decrements each cycle, and the state exits in the cycle timer==0.
REQ-018 Normal sequence SHALL be NS_GREEN -> NS_YELLOW -> CLR_A -> WE_GREEN -> WE_YELLOW -> CLR_B -> NS_GREEN.
REQ-019 On CLR_A or CLR_B expiry with ped_pending=1, the next state SHALL be WALK; on WALK expiry, the FSM SHALL proceed to the green that would otherwise have followed (WE_GREEN after CLR_A, NS_GREEN after CLR_B), tracked by a 1-bit next-direction register.
REQ-020 ped_pending SHALL be set by ped_req=1 in any non-FLASH state and cleared on the cycle WALK is entered; if ped_req=1 in that same cycle, set wins and ped_pending stays 1.
REQ-021 All durations SHALL satisfy 1 <= D <= 2**TIMER_W; out-of-range values are unsupported, and the timer SHALL never wrap below 0.
REQ-022 Lamp outputs SHALL be registered-state decodes with zero combinational dependency on ped_req or flash.

Reset
REQ-023 While reset=1, the block SHALL hold state=CLR_B, timer=ALL_RED_DURATION-1, next-direction=NS, ped_pending=0, blink phase=on.
REQ-024 During reset, outputs SHALL be ns=RED, we=RED, walk=0, ped_pending=0.
REQ-025 Reset asserted mid-phase SHALL immediately abandon the phase and its pending request.
REQ-026 After reset release, the first green SHALL be NS_GREEN after ALL_RED_DURATION cycles.

Configuration
REQ-027 With macro TLIGHT_FLASH_EN defined, flash=1 SHALL force FLASH on the next edge from any state.
REQ-028 In FLASH, ns=we=YELLOW during the on half and 000 during the off half, toggling every FLASH_HALF_PERIOD cycles starting with on.
REQ-029 In FLASH, walk=0, ped_req is ignored, and ped_pending is cleared.
REQ-030 With TLIGHT_FLASH_EN defined, flash deassertion SHALL exit FLASH to CLR_B with timer=ALL_RED_DURATION-1.
REQ-031 Without TLIGHT_FLASH_EN, the flash port SHALL remain present but ignored, and the FLASH state SHALL be unreachable.

Verification
REQ-032 Defaults, no requests, 100-cycle run: NS_GREEN 16 cycles, NS_YELLOW 4, CLR_A 2, WE_GREEN 16, WE_YELLOW 4, CLR_B 2; period 44.
REQ-033 1-cycle ped_req during WE_GREEN: ped_pending=1 next cycle; after CLR_B, walk=1 for 10 cycles with all lamps RED; then NS_GREEN; ped_pending=0 from WALK entry.
REQ-034 ped_req held high across WALK entry: ped_pending stays 1, and a second WALK follows the next clearance (CLR_A).
REQ-035 Reset pulse in cycle 7 of WE_GREEN: outputs RED/RED at once; after release, 2 cycles CLR_B, then NS_GREEN.
REQ-036 TLIGHT_FLASH_EN defined, flash=1 during NS_GREEN: next cycle ns=we=010 for 8 cycles, then 000 for 8, repeating; flash=0 -> CLR_B for 2 cycles -> NS_GREEN.
REQ-037 Boundary: all durations=1, TIMER_W=1: each state lasts exactly 1 cycle and the sequence repeats every 6 cycles.

Source files
------------

// File: rtl/tlight_v2.sv
// Two-way traffic light controller with latched pedestrian walk phase.
// Optional night flashing mode is built only when TLIGHT_FLASH_EN is defined.
module tlight_v2 #(
  parameter int TIMER_W           = 8,
  parameter int GREEN_DURATION    = 16,
  parameter int YELLOW_DURATION   = 4,
  parameter int ALL_RED_DURATION  = 2,
  parameter int WALK_DURATION     = 10,
  parameter int FLASH_HALF_PERIOD = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash,
  output logic [2:0] ns,
  output logic [2:0] we,
  output logic       walk,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    CLR_A,
    WE_GREEN,
    WE_YELLOW,
    CLR_B,
    WALK,
    FLASH
  } state_e;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  typedef logic [TIMER_W-1:0] tmr_t;

  localparam tmr_t LD_GREEN  = tmr_t'(GREEN_DURATION - 1);
  localparam tmr_t LD_YELLOW = tmr_t'(YELLOW_DURATION - 1);
  localparam tmr_t LD_CLR    = tmr_t'(ALL_RED_DURATION - 1);
  localparam tmr_t LD_WALK   = tmr_t'(WALK_DURATION - 1);
  localparam tmr_t LD_HALF   = tmr_t'(FLASH_HALF_PERIOD - 1);

  state_e state_q, state_d;
  tmr_t   timer_q, timer_d;
  // dir: 0 = NS green follows a walk, 1 = WE green follows
  logic   dir_q, dir_d;
  logic   pend_q, pend_d;
  logic   blink_q, blink_d;
  logic   flash_req;
  logic   expire;

`ifdef TLIGHT_FLASH_EN
  assign flash_req = flash;
`else
  logic unused_flash;
  assign unused_flash = flash;
  assign flash_req    = 1'b0;
`endif

  assign expire = (timer_q == '0);

  function automatic tmr_t load_of(input state_e s);
    tmr_t v;
    unique case (s)
      NS_GREEN, WE_GREEN:   v = LD_GREEN;
      NS_YELLOW, WE_YELLOW: v = LD_YELLOW;
      CLR_A, CLR_B:         v = LD_CLR;
      WALK:                 v = LD_WALK;
      FLASH:                v = LD_HALF;
    endcase
    return v;
  endfunction

  // State register; reset parks in clearance ahead of NS green
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CLR_B;
      timer_q <= LD_CLR;
      dir_q   <= 1'b0;
      pend_q  <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
    end
  end

  // Next-state: phase timing, walk insertion, flash override
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    blink_d = blink_q;
    pend_d  = pend_q | ped_req;
    if (flash_req) begin
      pend_d = 1'b0;
      if (state_q != FLASH) begin
        state_d = FLASH;
        timer_d = LD_HALF;
        blink_d = 1'b1;
      end else if (expire) begin
        timer_d = LD_HALF;
        blink_d = ~blink_q;
      end else begin
        timer_d = timer_q - tmr_t'(1);
      end
    end else if (state_q == FLASH) begin
      state_d = CLR_B;
      timer_d = LD_CLR;
      blink_d = 1'b1;
      pend_d  = 1'b0;
    end else if (!expire) begin
      timer_d = timer_q - tmr_t'(1);
    end else begin
      unique case (state_q)
        NS_GREEN:  state_d = NS_YELLOW;
        NS_YELLOW: state_d = CLR_A;
        WE_GREEN:  state_d = WE_YELLOW;
        WE_YELLOW: state_d = CLR_B;
        CLR_A: begin
          if (pend_q) begin
            state_d = WALK;
            dir_d   = 1'b1;
          end else begin
            state_d = WE_GREEN;
          end
        end
        CLR_B: begin
          if (pend_q) begin
            state_d = WALK;
            dir_d   = 1'b0;
          end else begin
            state_d = NS_GREEN;
          end
        end
        WALK:  state_d = dir_q ? WE_GREEN : NS_GREEN;
        FLASH: state_d = CLR_B;
      endcase
      timer_d = load_of(state_d);
      // entering walk serves the request; a same-cycle request re-arms it
      if (state_d == WALK) pend_d = ped_req;
    end
  end

  // Outputs decode registered state only
  always_comb begin
    ns          = RED;
    we          = RED;
    walk        = 1'b0;
    ped_pending = pend_q;
    unique case (state_q)
      NS_GREEN:  ns = GRN;
      NS_YELLOW: ns = YEL;
      WE_GREEN:  we = GRN;
      WE_YELLOW: we = YEL;
      WALK:      walk = 1'b1;
      FLASH: begin
        ns = blink_q ? YEL : DARK;
        we = blink_q ? YEL : DARK;
      end
      CLR_A, CLR_B: begin
        ns = RED;
        we = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_tlight_v2.sv
// Scoreboard bench for tlight_v2: default and minimum-duration instances
// driven by the same random ped_req / flash / reset stimulus.
module tb_tlight_v2;

  logic clk;
  logic rst;
  logic pr;
  logic fl;
  logic [2:0] ns0, we0, ns1, we1;
  logic walk0, pp0, walk1, pp1;

  tlight_v2 u0 (
    .clock(clk), .reset(rst), .ped_req(pr), .flash(fl),
    .ns(ns0), .we(we0), .walk(walk0), .ped_pending(pp0)
  );

  tlight_v2 #(
    .TIMER_W(1), .GREEN_DURATION(1), .YELLOW_DURATION(1),
    .ALL_RED_DURATION(1), .WALK_DURATION(1), .FLASH_HALF_PERIOD(1)
  ) u1 (
    .clock(clk), .reset(rst), .ped_req(pr), .flash(fl),
    .ns(ns1), .we(we1), .walk(walk1), .ped_pending(pp1)
  );

`ifdef TLIGHT_FLASH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  // phase ids used only by the reference model
  localparam int P_NSG = 0, P_NSY = 1, P_CLA = 2, P_WEG = 3;
  localparam int P_WEY = 4, P_CLB = 5, P_WLK = 6, P_FL = 7;

  int  dur [2][8];
  int  ph  [2];
  int  el  [2];
  bit  pend[2];
  bit  wdir[2];
  bit  blnk[2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit done   = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void mreset(int k);
    ph[k]   = P_CLB;
    el[k]   = 0;
    pend[k] = 0;
    wdir[k] = 0;
    blnk[k] = 1;
  endfunction

  // One clock of the behavioural model: count cycles spent in a phase
  function automatic void mstep(int k, bit r, bit req, bit f);
    int nx;
    if (r) begin
      mreset(k);
      return;
    end
    if (FE && f) begin
      pend[k] = 0;
      if (ph[k] != P_FL) begin
        ph[k] = P_FL; el[k] = 0; blnk[k] = 1;
      end else begin
        el[k]++;
        if (el[k] == dur[k][P_FL]) begin
          el[k] = 0; blnk[k] = !blnk[k];
        end
      end
      return;
    end
    if (ph[k] == P_FL) begin
      ph[k] = P_CLB; el[k] = 0; pend[k] = 0; blnk[k] = 1;
      return;
    end
    el[k]++;
    if (el[k] < dur[k][ph[k]]) begin
      pend[k] = pend[k] | req;
      return;
    end
    case (ph[k])
      P_NSG: nx = P_NSY;
      P_NSY: nx = P_CLA;
      P_WEG: nx = P_WEY;
      P_WEY: nx = P_CLB;
      P_CLA: begin
        nx = pend[k] ? P_WLK : P_WEG;
        if (pend[k]) wdir[k] = 1;
      end
      P_CLB: begin
        nx = pend[k] ? P_WLK : P_NSG;
        if (pend[k]) wdir[k] = 0;
      end
      default: nx = wdir[k] ? P_WEG : P_NSG;
    endcase
    pend[k] = (nx == P_WLK) ? req : (pend[k] | req);
    ph[k] = nx;
    el[k] = 0;
  endfunction

  function automatic logic [7:0] mexp(int k);
    logic [2:0] n, w;
    n = 3'b100;
    w = 3'b100;
    case (ph[k])
      P_NSG: n = 3'b001;
      P_NSY: n = 3'b010;
      P_WEG: w = 3'b001;
      P_WEY: w = 3'b010;
      P_FL: begin
        n = blnk[k] ? 3'b010 : 3'b000;
        w = n;
      end
      default: ;
    endcase
    return {n, w, ph[k] == P_WLK, pend[k]};
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got ns=%b we=%b walk=%b pend=%b exp ns=%b we=%b walk=%b pend=%b",
               nm, cyc, got[7:5], got[4:2], got[1], got[0],
               exp[7:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: every cycle the DUT presents lamps; pop and compare
  always @(negedge clk) begin
    if (!done) begin
      cyc++;
      if (q0.size() == 0 || q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty cyc %0d got q0=%0d q1=%0d exp >0",
                 cyc, q0.size(), q1.size());
      end else begin
        chk("dflt", {ns0, we0, walk0, pp0}, q0.pop_front());
        chk("min", {ns1, we1, walk1, pp1}, q1.pop_front());
      end
    end
  end

  initial begin
    int rst_hold;
    int pr_hold;
    int fl_hold;
    dur[0] = '{16, 4, 2, 16, 4, 2, 10, 8};
    dur[1] = '{1, 1, 1, 1, 1, 1, 1, 1};
    rst = 1; pr = 0; fl = 0;
    rst_hold = 3; pr_hold = 0; fl_hold = 0;
    mreset(0);
    mreset(1);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      mstep(0, rst, pr, fl);
      mstep(1, rst, pr, fl);
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 499) == 0) rst_hold = $urandom_range(1, 3);
      if (pr_hold > 0) pr_hold--;
      else if ($urandom_range(0, 59) == 0) pr_hold = $urandom_range(1, 30);
      if (fl_hold > 0) fl_hold--;
      else if ($urandom_range(0, 399) == 0) fl_hold = $urandom_range(10, 60);
      #2;
      rst = (rst_hold > 0);
      pr  = (pr_hold > 0) && ($urandom_range(0, 3) != 0);
      fl  = (fl_hold > 0);
      if (rst) begin
        mreset(0);
        mreset(1);
      end
      q0.push_back(mexp(0));
      q1.push_back(mexp(1));
    end
    @(negedge clk);
    #1;
    done = 1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got q0=%0d q1=%0d exp 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
